dllp_crc_scheduler: RTL and testbench

// - Shares the single combinational DLLP CRC engine (crc16_32bit, poly 0x100B, seed 0xFFFF)

---
 rtl/dll_tx_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/dllp_crc_scheduler.sv | 95 +++++++++
 tb/tb_dllp_crc_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_tx_pkg.sv
// Shared Data Link TX types: DLLP scheduler state encoding and DLLP field widths.
package dll_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } dllp_sched_state_t;

    localparam int DLLP_BODY_W = 32;
    localparam int DLLP_CRC_W  = 16;
    localparam int DLLP_W      = 48;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot gnt plus binary idx.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed and advances ptr.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dllp_crc_scheduler.sv
// Shares one DLLP CRC engine between NUM_REQ sources round-robin; emits {body, crc} on valid/ready.
// Latency: grant in the cycle req is seen in IDLE, dllp_valid two cycles later; one DLLP in flight.
// Backpressure: dllp_ready low parks the DLLP in HOLD indefinitely and blocks further grants.
module dllp_crc_scheduler
    import dll_tx_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DLLP_BODY_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           crc_en,
    output logic [DLLP_BODY_W-1:0]         crc_data,
    input  logic [DLLP_CRC_W-1:0]          crc_result,
    output logic                           dllp_valid,
    input  logic                           dllp_ready,
    output logic [DLLP_W-1:0]              dllp_out,
    output logic                           busy,
    output logic [CNT_W-1:0]               dllp_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dllp_sched_state_t      state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          arb_idx;
    logic [PW-1:0]          ptr_nxt;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [DLLP_BODY_W-1:0] body_q;
    logic [DLLP_BODY_W-1:0] sel_body;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        sel_body = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i]) sel_body = req_data[i*DLLP_BODY_W +: DLLP_BODY_W];
    end

    assign ptr_nxt  = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
    // Grant is only meaningful in IDLE; masked during reset so a held req cannot leak a pulse.
    assign gnt      = (rst && state == IDLE) ? arb_gnt : '0;
    assign busy     = (state != IDLE);
    // The captured body doubles as the engine input, so it holds its value outside CALC.
    assign crc_data = body_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            body_q     <= '0;
            crc_en     <= 1'b0;
            dllp_valid <= 1'b0;
            dllp_out   <= '0;
            dllp_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        body_q <= sel_body;
                        ptr    <= ptr_nxt;
                        crc_en <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    dllp_out   <= {body_q, crc_result};
                    dllp_valid <= 1'b1;
                    crc_en     <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (dllp_ready) begin
                        dllp_valid <= 1'b0;
                        dllp_cnt   <= dllp_cnt + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dllp_crc_scheduler.sv
// Bench for dllp_crc_scheduler: directed scenarios then random traffic against a transaction-level model.
module tb_dllp_crc_scheduler;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  gnt;
    logic          crc_en;
    logic [31:0]   crc_data;
    logic [15:0]   crc_result;
    logic          dllp_valid;
    logic          dllp_ready;
    logic [47:0]   dllp_out;
    logic          busy;
    logic [15:0]   dllp_cnt;

    logic [N-1:0]  w_req;
    logic [N*32-1:0] w_req_data;
    logic [N-1:0]  w_gnt;
    logic          w_crc_en;
    logic [31:0]   w_crc_data;
    logic [15:0]   w_crc_result;
    logic          w_valid;
    logic          w_ready;
    logic [47:0]   w_out;
    logic          w_busy;
    logic [3:0]    w_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Transaction-level model state
    int          t;
    bit          m_idle;
    int          m_gcyc;
    logic [47:0] m_exp;
    int          m_ptr;
    logic [15:0] m_cnt;
    logic [N-1:0] hold_mask;
    int          gq[$];
    int          gt[$];

    always #5 clk = ~clk;

    // Stand-in for the parent-level crc16_32bit engine: poly 0x100B, seed 0xFFFF, MSB first.
    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign crc_result   = crc16(crc_data);
    assign w_crc_result = crc16(w_crc_data);

    dllp_crc_scheduler #(.NUM_REQ(N), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .crc_en(crc_en), .crc_data(crc_data), .crc_result(crc_result),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_out(dllp_out),
        .busy(busy), .dllp_cnt(dllp_cnt)
    );

    dllp_crc_scheduler #(.NUM_REQ(N), .CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .req(w_req), .req_data(w_req_data), .gnt(w_gnt),
        .crc_en(w_crc_en), .crc_data(w_crc_data), .crc_result(w_crc_result),
        .dllp_valid(w_valid), .dllp_ready(w_ready), .dllp_out(w_out),
        .busy(w_busy), .dllp_cnt(w_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = set requester with the smallest cyclic distance from the pointer.
    function automatic int winner(input logic [N-1:0] r, input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++)
            if (r[i] && ((i - p + N) % N) < bestd) begin
                best  = i;
                bestd = (i - p + N) % N;
            end
        return best;
    endfunction

    // One clock: check outputs against the model, advance, apply the requester rule.
    task automatic step();
        int w;
        logic [N-1:0] eg;
        #1;
        w = -1;
        check("cnt", dllp_cnt, m_cnt);
        if (m_idle) begin
            w  = winner(req, m_ptr);
            eg = (w >= 0) ? N'(1 << w) : '0;
            check("gnt_idle", gnt, eg);
            check("busy_idle", busy, 0);
            check("valid_idle", dllp_valid, 0);
            check("crc_en_idle", crc_en, 0);
            if (w >= 0) begin
                m_idle = 1'b0;
                m_gcyc = t;
                m_exp  = {req_data[w*32 +: 32], crc16(req_data[w*32 +: 32])};
                m_ptr  = (w + 1) % N;
                gq.push_back(w);
                gt.push_back(t);
            end
        end else begin
            check("gnt_busy", gnt, 0);
            check("busy", busy, 1);
            check("crc_en", crc_en, (t == m_gcyc + 1));
            if (t == m_gcyc + 1) check("crc_data", crc_data, m_exp[47:16]);
            check("valid", dllp_valid, (t >= m_gcyc + 2));
            if (t >= m_gcyc + 2) begin
                check("dllp_out", dllp_out, m_exp);
                if (dllp_ready) begin
                    m_cnt++;
                    m_idle = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        t++;
        if (w >= 0) begin
            if (hold_mask[w]) req_data[w*32 +: 32] = $urandom;
            else              req[w] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_crc_en", crc_en, 0);
        check("rst_crc_data", crc_data, 0);
        check("rst_valid", dllp_valid, 0);
        check("rst_out", dllp_out, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", dllp_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        t++;
        rst    = 1'b1;
        m_idle = 1'b1;
        m_ptr  = 0;
        m_cnt  = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && !(req == '0 && m_idle); k++) step();
        check("drained", {req == '0, m_idle}, 2'b11);
    endtask

    initial begin
        int n0;
        int found;
        int t_acc;
        int hs;
        int guard;
        rst        = 1'b0;
        req        = '0;
        req_data   = '0;
        dllp_ready = 1'b1;
        w_req      = '0;
        w_req_data = '0;
        w_ready    = 1'b1;
        hold_mask  = '0;
        t          = 0;
        m_idle     = 1'b1;
        m_gcyc     = 0;
        m_exp      = '0;
        m_ptr      = 0;
        m_cnt      = '0;
        @(negedge clk);
        do_reset();

        // Single request, all-zero body
        req = 3'b001;
        req_data[31:0] = 32'h0;
        step();
        step();
        step();
        #1;
        check("single_cnt", dllp_cnt, 1);
        check("single_out", dllp_out, {32'h0, crc16(32'h0)});
        check("single_winner", gq[gq.size()-1], 0);

        // Three simultaneous requesters from a fresh pointer
        do_reset();
        gq.delete();
        gt.delete();
        req = 3'b111;
        req_data = {32'hC0000003, 32'hB0000002, 32'hA0000001};
        for (int k = 0; k < 9; k++) step();
        check("rr_n", gq.size(), 3);
        check("rr_0", gq[0], 0);
        check("rr_1", gq[1], 1);
        check("rr_2", gq[2], 2);
        check("rr_gap01", gt[1] - gt[0], 3);
        check("rr_gap12", gt[2] - gt[1], 3);

        // Backpressure: 10 stalled cycles in HOLD with another source waiting
        req = 3'b001;
        req_data[31:0] = $urandom;
        dllp_ready = 1'b0;
        step();
        step();
        req[1] = 1'b1;
        req_data[63:32] = $urandom;
        step();
        for (int k = 0; k < 10; k++) step();
        dllp_ready = 1'b1;
        t_acc = t;
        step();
        step();
        check("bp_next_winner", gq[gq.size()-1], 1);
        check("bp_next_gap", gt[gt.size()-1] - t_acc, 1);
        drain();

        // Fairness: source 0 re-requests continuously, source 2 raised once
        hold_mask = 3'b001;
        req[0] = 1'b1;
        req_data[31:0] = $urandom;
        for (int k = 0; k < 4; k++) step();
        req[2] = 1'b1;
        req_data[95:64] = $urandom;
        n0 = gq.size();
        found = -1;
        for (int k = 0; k < 30 && found < 0; k++) begin
            step();
            for (int j = n0; j < gq.size(); j++)
                if (gq[j] == 2 && found < 0) found = j;
        end
        check("fair_within2", (found >= 0) && (found - n0 <= 1), 1);
        hold_mask = '0;
        drain();

        // Reset while in CALC
        req = 3'b010;
        req_data[63:32] = $urandom;
        step();
        do_reset();
        step();
        step();
        // Pointer must be back at 0
        req = 3'b111;
        req_data = {$urandom, $urandom, $urandom};
        #1;
        check("ptr_after_rst", gnt, 3'b001);
        step();
        // Reset while in HOLD
        dllp_ready = 1'b0;
        step();
        step();
        do_reset();
        dllp_ready = 1'b1;
        drain();

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*32 +: 32] = $urandom;
                end
            dllp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else step();
        end
        dllp_ready = 1'b1;
        drain();

        // Counter wrap on the CNT_W=4 instance
        w_req = 3'b001;
        w_req_data[31:0] = $urandom;
        hs = 0;
        guard = 0;
        while (hs < 17 && guard < 200) begin
            @(negedge clk);
            if (w_valid && w_ready) hs++;
            guard++;
        end
        w_req = '0;
        check("wrap_handshakes", hs, 17);
        @(posedge clk);
        @(negedge clk);
        check("wrap_cnt", w_cnt, 4'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
